clk_divider_prog: RTL and testbench
===================================

Name: clk_divider_prog

Overview:
- Multi-channel, runtime-programmable strobe generator. Successor to the fixed-divisor single-channel clock divider.
- Each channel produces a one-cycle strobe every D enabled clock cycles, plus a square-wave phase output with period 2·D.
- Divisors are loaded from a control bus (APB register file) through shadow registers, so a change takes effect glitch-free at the next terminal count.
- Feeds the VGA timing and char-generator blink/pixel-enable logic.

Parameters:
CHANNELS, 2, number of independent divider channels (≥1)
DIV_W, 16, divisor width in bits (≥2)
RST_DIV, 2, divisor loaded into every channel at reset (1 ≤ RST_DIV < 2**DIV_W)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
en_i  in  CHANNELS  per-channel count enable
div_i  in  CHANNELS*DIV_W  new divisor; channel c in bits [c*DIV_W +: DIV_W]
div_we_i  in  CHANNELS  per-channel divisor write strobe
restart_i  in  CHANNELS  per-channel synchronous restart
strb_o  out  CHANNELS  registered one-cycle strobe
phase_o  out  CHANNELS  registered square wave, toggles on each strobe
pending_o  out  CHANNELS  shadow divisor written but not yet applied

Behaviour:
- All channels are identical and fully independent; there is no cross-channel interaction.
- Per-channel state: cnt (DIV_W bits), active_div, shadow_div, pending, strb_o, phase_o.
- Reset (rst_i=1 at posedge):
  - cnt=0, active_div=shadow_div=RST_DIV, pending=0, strb_o=0, phase_o=0.
  - Reset overrides every other input.
- Priority per channel: rst_i > restart_i > en_i. div_we_i is accepted in every non-reset cycle.
- Effective divisor: Deff(x) = 1 if x==0, else x. A divisor of 0 is never an error.
- Reload value R:
  - R = Deff(div_i) when div_we_i=1 in that cycle;
  - else R = Deff(shadow_div) when pending=1;
  - else R = Deff(active_div).
- Terminal event T = en_i & ~restart_i & (cnt==0).
- On T:
  - cnt <= R-1;
  - active_div <= the source of R (raw value, not Deff);
  - pending <= 0;
  - phase_o toggles.
- en_i=1, cnt≠0, no restart: cnt <= cnt-1.
- en_i=0, no restart: cnt, phase_o and active_div hold.
- strb_o <= T every cycle. So strb_o is high for exactly the cycle after T (1-cycle latency) and is 0 whenever en_i was 0 in the previous cycle.
- div_we_i without T (and no restart): shadow_div <= div_i, pending <= 1. A later write before the reload overwrites the shadow (last write wins).
- div_we_i coinciding with T: the new value is applied directly, shadow_div <= div_i, pending stays 0.
- restart_i=1:
  - cnt <= 0, strb_o <= 0, phase_o <= 0;
  - pending divisor, or div_i if div_we_i=1 in the same cycle, is copied to active_div and shadow_div; pending <= 0.
  - The first strobe follows the first enabled cycle after restart.
- Period: with D=active divisor and en_i constantly 1, strb_o pulses every D cycles. D≤1 gives strb_o constantly 1 and phase_o toggling every cycle.
- Wrap: cnt never underflows; reload always occurs at cnt==0.
- Arithmetic is unsigned, DIV_W bits. R-1 never wraps because R ≥ 1.
- pending_o = pending, registered.

Test Plan:
- Reset defaults: rst_i 1→0, en_i=1, RST_DIV=2 → strb_o 1,0,1,0… starting the first cycle after reset release; phase_o 1,1,0,0,1,…; pending_o=0.
- Shadow load: D=2, write div_i=5 while cnt≠0 → pending_o=1 until the next terminal event, then strobes every 5 cycles and pending_o=0. Strobe spacing at the switch: 2 then 5.
- Divisor edges: write 0, and separately 1 → strb_o constantly 1 after reload, phase_o toggles every cycle. Write 2**DIV_W-1 → strobe spacing 65535 with DIV_W=16.
- Enable gating and simultaneous write: with D=4, deassert en_i for 3 cycles mid-count → strb_o=0 and count frozen, resumes with total spacing 4+3. A div_we_i on the same cycle as T → new divisor used immediately, pending_o stays 0.
- Restart and reset mid-operation: restart_i with pending=7 → strb_o=0, phase_o=0 next cycle, then strobe after the first enabled cycle and spacing 7. rst_i asserted mid-count alongside div_we_i and restart_i → all state returns to reset values, write ignored.
- Channel independence: CHANNELS=2, ch0 D=3 and ch1 D=5 with staggered enables and restarts → each channel's strobe spacing is unaffected by the other's activity.

Source files
------------

// File: rtl/clk_divider_prog_if.sv
// Control/status bundle for the programmable strobe generator: per-channel enables,
// divisor writes and restarts in; strobe, square-wave phase and pending flag out.
interface clk_divider_prog_if #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 16
);
    logic [CHANNELS-1:0]       en_i;
    logic [CHANNELS*DIV_W-1:0] div_i;
    logic [CHANNELS-1:0]       div_we_i;
    logic [CHANNELS-1:0]       restart_i;
    logic [CHANNELS-1:0]       strb_o;
    logic [CHANNELS-1:0]       phase_o;
    logic [CHANNELS-1:0]       pending_o;

    modport master (
        output en_i, div_i, div_we_i, restart_i,
        input  strb_o, phase_o, pending_o
    );

    modport slave (
        input  en_i, div_i, div_we_i, restart_i,
        output strb_o, phase_o, pending_o
    );
endinterface

// File: rtl/clk_divider_prog.sv
// Multi-channel programmable strobe generator. Each channel counts enabled cycles down
// to zero, strobes, and reloads from a shadowed divisor so changes land on a terminal count.
module clk_divider_prog #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 16,
    parameter int RST_DIV  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    clk_divider_prog_if.slave bus
);
    localparam logic [DIV_W-1:0] RST_VAL = DIV_W'(RST_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] active_div;
        logic [DIV_W-1:0] shadow_div;
        logic             pending;
        logic             strb;
        logic             phase;

        logic [DIV_W-1:0] div_new;
        logic [DIV_W-1:0] src_div;
        logic [DIV_W-1:0] reload;
        logic             term;

        // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
        always_comb begin
            div_new = bus.div_i[c*DIV_W +: DIV_W];
            if (bus.div_we_i[c]) begin
                src_div = div_new;
            end else if (pending) begin
                src_div = shadow_div;
            end else begin
                src_div = active_div;
            end
            // A zero divisor behaves as one; the raw value is still what gets stored.
            reload = (src_div == '0) ? ONE : src_div;
            term   = bus.en_i[c] & ~bus.restart_i[c] & (cnt == '0);
        end

        // NOTE: state updates use non-blocking assignments so all registers sample
        // the same pre-edge values regardless of statement order.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt        <= '0;
                active_div <= RST_VAL;
                shadow_div <= RST_VAL;
                pending    <= 1'b0;
                strb       <= 1'b0;
                phase      <= 1'b0;
            end else if (bus.restart_i[c]) begin
                cnt     <= '0;
                strb    <= 1'b0;
                phase   <= 1'b0;
                pending <= 1'b0;
                if (bus.div_we_i[c]) begin
                    active_div <= div_new;
                    shadow_div <= div_new;
                end else if (pending) begin
                    active_div <= shadow_div;
                end
            end else begin
                strb <= term;
                if (term) begin
                    cnt        <= reload - ONE;
                    active_div <= src_div;
                    pending    <= 1'b0;
                    phase      <= ~phase;
                    if (bus.div_we_i[c]) begin
                        shadow_div <= div_new;
                    end
                end else begin
                    if (bus.en_i[c]) begin
                        cnt <= cnt - ONE;
                    end
                    // Written while mid-count: park in the shadow until the next reload.
                    if (bus.div_we_i[c]) begin
                        shadow_div <= div_new;
                        pending    <= 1'b1;
                    end
                end
            end
        end

        assign bus.strb_o[c]    = strb;
        assign bus.phase_o[c]   = phase;
        assign bus.pending_o[c] = pending;
    end
endmodule

// File: tb/tb_clk_divider_prog.sv
// Self-checking bench for clk_divider_prog: a per-channel behavioural model is compared
// against the DUT after every clock, with directed literal checks on strobe spacing.
module tb_clk_divider_prog;
    localparam int CH = 2;
    localparam int DW = 16;
    localparam int RD = 2;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    clk_divider_prog_if #(.CHANNELS(CH), .DIV_W(DW)) bus ();

    clk_divider_prog #(.CHANNELS(CH), .DIV_W(DW), .RST_DIV(RD)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    typedef struct {
        int left;    // enabled cycles still to go before the next terminal event
        int div;     // divisor in force
        int shadow;  // last written divisor
        bit pend;
        bit strb;
        int nstr;    // strobes since reset/restart; phase is its parity
    } ch_model_t;

    ch_model_t m [CH];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int last_s [CH];
    int gap    [CH];
    logic [CH-1:0] en, we, rs;
    int dv [CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cycle, act, exp);
        end
    endtask

    function automatic int deff(int x);
        return (x == 0) ? 1 : x;
    endfunction

    function automatic void model_step(int c);
        int src;
        if (rst_i) begin
            m[c] = '{0, RD, RD, 1'b0, 1'b0, 0};
        end else if (rs[c]) begin
            m[c].left = 0;
            m[c].strb = 1'b0;
            m[c].nstr = 0;
            if (we[c]) begin
                m[c].div    = dv[c];
                m[c].shadow = dv[c];
            end else if (m[c].pend) begin
                m[c].div = m[c].shadow;
            end
            m[c].pend = 1'b0;
        end else begin
            m[c].strb = en[c] && (m[c].left == 0);
            if (m[c].strb) begin
                src = we[c] ? dv[c] : (m[c].pend ? m[c].shadow : m[c].div);
                m[c].div = src;
                if (we[c]) m[c].shadow = dv[c];
                m[c].pend = 1'b0;
                m[c].left = deff(src) - 1;
                m[c].nstr++;
            end else begin
                if (en[c]) m[c].left--;
                if (we[c]) begin
                    m[c].shadow = dv[c];
                    m[c].pend   = 1'b1;
                end
            end
        end
    endfunction

    task automatic tick();
        bus.en_i      = en;
        bus.div_we_i  = we;
        bus.restart_i = rs;
        for (int c = 0; c < CH; c++) bus.div_i[c*DW +: DW] = DW'(dv[c]);
        for (int c = 0; c < CH; c++) model_step(c);
        @(posedge clk_i);
        #1;
        cycle++;
        for (int c = 0; c < CH; c++) begin
            check($sformatf("model_strb%0d", c), 32'(bus.strb_o[c]), 32'(m[c].strb));
            check($sformatf("model_phase%0d", c), 32'(bus.phase_o[c]), 32'(m[c].nstr % 2));
            check($sformatf("model_pend%0d", c), 32'(bus.pending_o[c]), 32'(m[c].pend));
            if (bus.strb_o[c] === 1'b1) begin
                gap[c]    = (last_s[c] < 0) ? 0 : cycle - last_s[c];
                last_s[c] = cycle;
            end
        end
    endtask

    task automatic wait_strobe(input int c, input int limit, input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            tick();
            if (bus.strb_o[c] === 1'b1) seen = 1'b1;
        end
        check({name, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        bit [3:0] e_s;
        bit [3:0] e_p;
        bit [2:0] e_r;
        int n;

        e_s = 4'b0101;
        e_p = 4'b0011;
        e_r = 3'b101;
        en = '1; we = '0; rs = '0;
        for (int c = 0; c < CH; c++) begin
            dv[c] = 0; last_s[c] = -1; gap[c] = 0;
        end

        // Reset defaults
        rst_i = 1'b1;
        tick(); tick();
        check("rst_pend", 32'(bus.pending_o), 32'd0);
        rst_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst_strb0", 32'(bus.strb_o[0]), 32'(e_s[k]));
            check("rst_strb1", 32'(bus.strb_o[1]), 32'(e_s[k]));
            check("rst_phase0", 32'(bus.phase_o[0]), 32'(e_p[k]));
        end

        // Shadow load 2 -> 5
        tick();
        dv[0] = 5; we[0] = 1'b1; tick(); we[0] = 1'b0;
        check("shadow_pend", 32'(bus.pending_o[0]), 32'd1);
        wait_strobe(0, 10, "shadow_switch");
        check("shadow_pend_clr", 32'(bus.pending_o[0]), 32'd0);
        check("shadow_gap_2", 32'(gap[0]), 32'd2);
        wait_strobe(0, 10, "shadow_5a");
        check("shadow_gap_5a", 32'(gap[0]), 32'd5);
        wait_strobe(0, 10, "shadow_5b");
        check("shadow_gap_5b", 32'(gap[0]), 32'd5);

        // Divisor 1, then 0 written on a terminal cycle
        dv[0] = 1; we[0] = 1'b1; tick(); we[0] = 1'b0;
        wait_strobe(0, 10, "div1_load");
        for (int k = 0; k < 4; k++) begin
            tick();
            check("div1_strb", 32'(bus.strb_o[0]), 32'd1);
            check("div1_gap", 32'(gap[0]), 32'd1);
        end
        dv[0] = 0; we[0] = 1'b1; tick(); we[0] = 1'b0;
        check("div0_pend", 32'(bus.pending_o[0]), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("div0_gap", 32'(gap[0]), 32'd1);
        end

        // Enable gating with D=4 applied on a terminal cycle
        dv[0] = 4; we[0] = 1'b1; tick(); we[0] = 1'b0;
        check("d4_direct_pend", 32'(bus.pending_o[0]), 32'd0);
        check("d4_direct_strb", 32'(bus.strb_o[0]), 32'd1);
        tick();
        en[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("gate_strb", 32'(bus.strb_o[0]), 32'd0);
        end
        en[0] = 1'b1;
        wait_strobe(0, 10, "gate_resume");
        check("gate_gap_7", 32'(gap[0]), 32'd7);

        // Write coinciding with the terminal event
        for (int k = 0; k < 3; k++) begin
            tick();
            check("d4_mid_strb", 32'(bus.strb_o[0]), 32'd0);
        end
        dv[0] = 6; we[0] = 1'b1; tick(); we[0] = 1'b0;
        check("wt_strb", 32'(bus.strb_o[0]), 32'd1);
        check("wt_pend", 32'(bus.pending_o[0]), 32'd0);
        check("wt_gap_4", 32'(gap[0]), 32'd4);
        wait_strobe(0, 10, "wt_next");
        check("wt_gap_6", 32'(gap[0]), 32'd6);

        // Restart with a pending divisor of 7
        dv[0] = 7; we[0] = 1'b1; tick(); we[0] = 1'b0;
        check("rs_pend_set", 32'(bus.pending_o[0]), 32'd1);
        tick();
        rs[0] = 1'b1; tick(); rs[0] = 1'b0;
        check("rs_strb", 32'(bus.strb_o[0]), 32'd0);
        check("rs_phase", 32'(bus.phase_o[0]), 32'd0);
        check("rs_pend", 32'(bus.pending_o[0]), 32'd0);
        en[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rs_idle_strb", 32'(bus.strb_o[0]), 32'd0);
        end
        en[0] = 1'b1;
        tick();
        check("rs_first_strb", 32'(bus.strb_o[0]), 32'd1);
        wait_strobe(0, 10, "rs_next");
        check("rs_gap_7", 32'(gap[0]), 32'd7);

        // Reset mid-count alongside a write and a restart
        tick(); tick();
        rst_i = 1'b1; we = '1; rs = '1; dv[0] = 9; dv[1] = 9;
        tick();
        rst_i = 1'b0; we = '0; rs = '0;
        check("rst_mid_strb", 32'(bus.strb_o), 32'd0);
        check("rst_mid_phase", 32'(bus.phase_o), 32'd0);
        check("rst_mid_pend", 32'(bus.pending_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_mid_seq", 32'(bus.strb_o[0]), 32'(e_r[k]));
        end

        // Channel independence: ch0 D=3, ch1 D=5
        dv[0] = 3; dv[1] = 5; we = '1; rs = '1; tick(); we = '0; rs = '0;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            en[1] = ($urandom_range(0, 2) != 0);
            rs[1] = ($urandom_range(0, 15) == 0);
            tick();
            if (bus.strb_o[0] === 1'b1) begin
                n++;
                if (n >= 2) check("indep_gap_ch0", 32'(gap[0]), 32'd3);
            end
        end
        en = '1; rs = '1; tick(); rs = '0;
        n = 0;
        for (int k = 0; k < 80; k++) begin
            en[0] = ($urandom_range(0, 2) != 0);
            rs[0] = ($urandom_range(0, 15) == 0);
            tick();
            if (bus.strb_o[1] === 1'b1) begin
                n++;
                if (n >= 2) check("indep_gap_ch1", 32'(gap[1]), 32'd5);
            end
        end
        rs = '0; en = '1;

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < CH; c++) begin
                en[c] = ($urandom_range(0, 9) != 0);
                we[c] = ($urandom_range(0, 15) == 0);
                rs[c] = ($urandom_range(0, 63) == 0);
                dv[c] = $urandom_range(0, 9);
            end
            rst_i = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst_i = 1'b0; en = '1; we = '0; rs = '0;

        // Largest divisor
        dv[0] = 65535; we[0] = 1'b1; rs[0] = 1'b1; tick(); we[0] = 1'b0; rs[0] = 1'b0;
        tick();
        check("big_first_strb", 32'(bus.strb_o[0]), 32'd1);
        wait_strobe(0, 70000, "big_next");
        check("big_gap", 32'(gap[0]), 32'd65535);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
